// File: rtl/cp0_tlb_seq_if.sv
// Request/response bundle between cp0/MEM and the TLB maintenance sequencer.
// The master drives commands and operands; the slave returns stall, completion and results.
interface cp0_tlb_seq_if;
    logic        cmd_valid_i;
    logic [3:0]  cmd_i;
    logic        flush_i;
    logic [31:0] index_i;
    logic [31:0] random_i;
    logic [31:0] pagemask_i;
    logic [31:0] entryhi_i;
    logic [31:0] entrylo0_i;
    logic [31:0] entrylo1_i;
    logic        busy_o;
    logic        done_o;
    logic        wb_index_we_o;
    logic        wb_entry_we_o;
    logic [31:0] index_o;
    logic [31:0] pagemask_o;
    logic [31:0] entryhi_o;
    logic [31:0] entrylo0_o;
    logic [31:0] entrylo1_o;

    modport slave (
        input  cmd_valid_i, cmd_i, flush_i, index_i, random_i, pagemask_i, entryhi_i,
               entrylo0_i, entrylo1_i,
        output busy_o, done_o, wb_index_we_o, wb_entry_we_o, index_o, pagemask_o, entryhi_o,
               entrylo0_o, entrylo1_o
    );

    modport master (
        output cmd_valid_i, cmd_i, flush_i, index_i, random_i, pagemask_i, entryhi_i,
               entrylo0_i, entrylo1_i,
        input  busy_o, done_o, wb_index_we_o, wb_entry_we_o, index_o, pagemask_o, entryhi_o,
               entrylo0_o, entrylo1_o
    );
endinterface

// File: rtl/cp0_tlb_seq.sv
// MIPS TLBP/TLBR/TLBWI/TLBWR sequencer with its own JTLB array.
// Probe scans one entry per cycle; read and write take one cycle; results return via strobes.
module cp0_tlb_seq #(
    parameter int unsigned TLB_LINE  = 16,
    parameter int unsigned TLB_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    cp0_tlb_seq_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StProbe, StRead, StWrite, StDone} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             op_cmd_q, op_cmd_d;
    logic [TLB_WIDTH-1:0]   op_idx_q, op_idx_d;
    logic [18:0]            op_vpn2_q, op_vpn2_d;
    logic [7:0]             op_asid_q, op_asid_d;
    logic [15:0]            op_mask_q, op_mask_d;
    logic [25:0]            op_lo0_q, op_lo0_d;
    logic [25:0]            op_lo1_q, op_lo1_d;
    logic [TLB_WIDTH-1:0]   probe_idx_q, probe_idx_d;
    logic [31:0]            index_q, index_d;
    logic [31:0]            pagemask_q, pagemask_d;
    logic [31:0]            entryhi_q, entryhi_d;
    logic [31:0]            entrylo0_q, entrylo0_d;
    logic [31:0]            entrylo1_q, entrylo1_d;

    logic [18:0] tlb_vpn2_q [TLB_LINE];
    logic [7:0]  tlb_asid_q [TLB_LINE];
    logic [15:0] tlb_mask_q [TLB_LINE];
    logic        tlb_g_q    [TLB_LINE];
    logic [25:0] tlb_lo0_q  [TLB_LINE];
    logic [25:0] tlb_lo1_q  [TLB_LINE];

    logic        cmd_onehot;
    logic        accept;
    logic        wr_en;
    logic [18:0] probe_mask;
    logic        probe_hit;
    logic        probe_last;

    // Bits of the cp0 registers that carry no TLB state.
    logic unused_bits;
    assign unused_bits = ^{bus.index_i[31:TLB_WIDTH], bus.random_i[31:TLB_WIDTH],
                           bus.pagemask_i[31:29], bus.pagemask_i[12:0], bus.entryhi_i[12:8],
                           bus.entrylo0_i[31:26], bus.entrylo1_i[31:26]};

    assign cmd_onehot = (bus.cmd_i != 4'd0) && ((bus.cmd_i & (bus.cmd_i - 4'd1)) == 4'd0);
    assign accept     = (state_q == StIdle) && bus.cmd_valid_i && cmd_onehot && !bus.flush_i;

    assign probe_mask = {3'b0, tlb_mask_q[probe_idx_q]};
    assign probe_hit  = ((tlb_vpn2_q[probe_idx_q] & ~probe_mask) == (op_vpn2_q & ~probe_mask)) &&
                        (tlb_g_q[probe_idx_q] || (tlb_asid_q[probe_idx_q] == op_asid_q));
    assign probe_last = (probe_idx_q == TLB_WIDTH'(TLB_LINE - 1));

    always_comb begin
        state_d     = state_q;
        op_cmd_d    = op_cmd_q;
        op_idx_d    = op_idx_q;
        op_vpn2_d   = op_vpn2_q;
        op_asid_d   = op_asid_q;
        op_mask_d   = op_mask_q;
        op_lo0_d    = op_lo0_q;
        op_lo1_d    = op_lo1_q;
        probe_idx_d = probe_idx_q;
        index_d     = index_q;
        pagemask_d  = pagemask_q;
        entryhi_d   = entryhi_q;
        entrylo0_d  = entrylo0_q;
        entrylo1_d  = entrylo1_q;
        wr_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_cmd_d    = bus.cmd_i;
                    op_idx_d    = bus.cmd_i[3] ? bus.random_i[TLB_WIDTH-1:0]
                                               : bus.index_i[TLB_WIDTH-1:0];
                    op_vpn2_d   = bus.entryhi_i[31:13];
                    op_asid_d   = bus.entryhi_i[7:0];
                    op_mask_d   = bus.pagemask_i[28:13];
                    op_lo0_d    = bus.entrylo0_i[25:0];
                    op_lo1_d    = bus.entrylo1_i[25:0];
                    probe_idx_d = '0;
                    unique case (bus.cmd_i)
                        4'b0001: state_d = StProbe;
                        4'b0010: state_d = StRead;
                        4'b0100: state_d = StWrite;
                        4'b1000: state_d = StWrite;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StProbe: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else if (probe_hit) begin
                    index_d = 32'(probe_idx_q);
                    state_d = StDone;
                end else if (probe_last) begin
                    index_d = 32'h8000_0000;
                    state_d = StDone;
                end else begin
                    probe_idx_d = probe_idx_q + TLB_WIDTH'(1);
                end
            end
            StRead: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else begin
                    pagemask_d = {3'b0, tlb_mask_q[op_idx_q], 13'b0};
                    entryhi_d  = {tlb_vpn2_q[op_idx_q], 5'b0, tlb_asid_q[op_idx_q]};
                    entrylo0_d = {6'b0, tlb_lo0_q[op_idx_q][25:1], tlb_g_q[op_idx_q]};
                    entrylo1_d = {6'b0, tlb_lo1_q[op_idx_q][25:1], tlb_g_q[op_idx_q]};
                    state_d    = StDone;
                end
            end
            // A write already past accept always commits; flush cannot cancel it.
            StWrite: begin
                wr_en   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            op_cmd_q    <= '0;
            op_idx_q    <= '0;
            op_vpn2_q   <= '0;
            op_asid_q   <= '0;
            op_mask_q   <= '0;
            op_lo0_q    <= '0;
            op_lo1_q    <= '0;
            probe_idx_q <= '0;
            index_q     <= '0;
            pagemask_q  <= '0;
            entryhi_q   <= '0;
            entrylo0_q  <= '0;
            entrylo1_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_cmd_q    <= op_cmd_d;
            op_idx_q    <= op_idx_d;
            op_vpn2_q   <= op_vpn2_d;
            op_asid_q   <= op_asid_d;
            op_mask_q   <= op_mask_d;
            op_lo0_q    <= op_lo0_d;
            op_lo1_q    <= op_lo1_d;
            probe_idx_q <= probe_idx_d;
            index_q     <= index_d;
            pagemask_q  <= pagemask_d;
            entryhi_q   <= entryhi_d;
            entrylo0_q  <= entrylo0_d;
            entrylo1_q  <= entrylo1_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLB_LINE; i++) begin
                tlb_vpn2_q[i] <= '0;
                tlb_asid_q[i] <= '0;
                tlb_mask_q[i] <= '0;
                tlb_g_q[i]    <= 1'b0;
                tlb_lo0_q[i]  <= '0;
                tlb_lo1_q[i]  <= '0;
            end
        end else if (wr_en) begin
            tlb_vpn2_q[op_idx_q] <= op_vpn2_q;
            tlb_asid_q[op_idx_q] <= op_asid_q;
            tlb_mask_q[op_idx_q] <= op_mask_q;
            tlb_g_q[op_idx_q]    <= op_lo0_q[0] & op_lo1_q[0];
            tlb_lo0_q[op_idx_q]  <= op_lo0_q;
            tlb_lo1_q[op_idx_q]  <= op_lo1_q;
        end
    end

    assign bus.busy_o        = ((state_q != StIdle) && (state_q != StDone)) ||
                               ((state_q == StIdle) && bus.cmd_valid_i && cmd_onehot);
    assign bus.done_o        = (state_q == StDone);
    assign bus.wb_index_we_o = (state_q == StDone) && op_cmd_q[0];
    assign bus.wb_entry_we_o = (state_q == StDone) && op_cmd_q[1];
    assign bus.index_o       = index_q;
    assign bus.pagemask_o    = pagemask_q;
    assign bus.entryhi_o     = entryhi_q;
    assign bus.entrylo0_o    = entrylo0_q;
    assign bus.entrylo1_o    = entrylo1_q;

endmodule

// File: tb/tb_cp0_tlb_seq.sv
// Directed bench for cp0_tlb_seq: a vector table of TLB commands with hand-computed results,
// followed by hand-written flush, illegal-command and reset-during-command sequences.
module tb_cp0_tlb_seq;

    localparam logic [3:0] CmdP  = 4'b0001;
    localparam logic [3:0] CmdR  = 4'b0010;
    localparam logic [3:0] CmdWi = 4'b0100;
    localparam logic [3:0] CmdWr = 4'b1000;

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic [31:0] index;
        logic [31:0] random;
        logic [31:0] pagemask;
        logic [31:0] entryhi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        int          cycles;
        logic [31:0] e_index;
        logic [31:0] e_pagemask;
        logic [31:0] e_entryhi;
        logic [31:0] e_lo0;
        logic [31:0] e_lo1;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    cp0_tlb_seq_if bus ();

    cp0_tlb_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] c, input logic [31:0] idx,
                                input logic [31:0] rnd, input logic [31:0] pm,
                                input logic [31:0] hi, input logic [31:0] l0,
                                input logic [31:0] l1, input int cyc, input logic [31:0] ei,
                                input logic [31:0] epm, input logic [31:0] ehi,
                                input logic [31:0] el0, input logic [31:0] el1);
        vec_t v;
        v.name = n;  v.cmd = c;  v.index = idx;  v.random = rnd;  v.pagemask = pm;
        v.entryhi = hi;  v.lo0 = l0;  v.lo1 = l1;  v.cycles = cyc;  v.e_index = ei;
        v.e_pagemask = epm;  v.e_entryhi = ehi;  v.e_lo0 = el0;  v.e_lo1 = el1;
        return v;
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after a rising edge.
    task automatic run_vec(input vec_t v);
        int n;
        bit seen;
        bus.cmd_i      = v.cmd;
        bus.index_i    = v.index;
        bus.random_i   = v.random;
        bus.pagemask_i = v.pagemask;
        bus.entryhi_i  = v.entryhi;
        bus.entrylo0_i = v.lo0;
        bus.entrylo1_i = v.lo1;
        bus.cmd_valid_i = 1'b1;
        #1;
        chk({v.name, " busy@accept"}, 32'(bus.busy_o), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done_o) seen = 1'b1;
        end
        chk({v.name, " latency"}, 32'(n), 32'(v.cycles));
        if (seen) begin
            chk({v.name, " busy@done"}, 32'(bus.busy_o), 32'd0);
            chk({v.name, " wb_index_we"}, 32'(bus.wb_index_we_o), 32'(v.cmd == CmdP));
            chk({v.name, " wb_entry_we"}, 32'(bus.wb_entry_we_o), 32'(v.cmd == CmdR));
            if (v.cmd == CmdP) chk({v.name, " index_o"}, bus.index_o, v.e_index);
            if (v.cmd == CmdR) begin
                chk({v.name, " pagemask_o"}, bus.pagemask_o, v.e_pagemask);
                chk({v.name, " entryhi_o"}, bus.entryhi_o, v.e_entryhi);
                chk({v.name, " entrylo0_o"}, bus.entrylo0_o, v.e_lo0);
                chk({v.name, " entrylo1_o"}, bus.entrylo1_o, v.e_lo1);
            end
        end
        bus.cmd_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk({v.name, " done pulse width"}, 32'(bus.done_o), 32'd0);
        chk({v.name, " strobes low"}, 32'({bus.wb_index_we_o, bus.wb_entry_we_o}), 32'd0);
        chk({v.name, " idle busy"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic count_done(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) cnt++;
        end
    endtask

    vec_t vecs[12];

    initial begin
        int cnt;
        int busy_cnt;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i = '0;
        bus.flush_i = 1'b0;
        bus.index_i = '0;
        bus.random_i = '0;
        bus.pagemask_i = '0;
        bus.entryhi_i = '0;
        bus.entrylo0_i = '0;
        bus.entrylo1_i = '0;

        // hi 0x0040_0012: VPN2 0x200, ASID 0x12. Stored G = lo0.G & lo1.G, read back in both.
        vecs[0]  = mk("p_miss_empty", CmdP, 0, 0, 0, 32'h0040_0012, 0, 0, 17,
                      32'h8000_0000, 0, 0, 0, 0);
        vecs[1]  = mk("wi5_nog", CmdWi, 5, 0, 0, 32'h0040_0012, 32'h40, 32'h47, 2, 0, 0, 0, 0, 0);
        vecs[2]  = mk("p_hit5", CmdP, 0, 0, 0, 32'h0040_0012, 0, 0, 7, 32'd5, 0, 0, 0, 0);
        vecs[3]  = mk("p_asid_miss", CmdP, 0, 0, 0, 32'h0040_0013, 0, 0, 17,
                      32'h8000_0000, 0, 0, 0, 0);
        vecs[4]  = mk("r5_nog", CmdR, 5, 0, 0, 0, 0, 0, 2, 0, 0, 32'h0040_0012, 32'h40, 32'h46);
        vecs[5]  = mk("wi5_g", CmdWi, 5, 0, 0, 32'h0040_0012, 32'h41, 32'h47, 2, 0, 0, 0, 0, 0);
        vecs[6]  = mk("p_global_hit", CmdP, 0, 0, 0, 32'h0040_0013, 0, 0, 7, 32'd5, 0, 0, 0, 0);
        vecs[7]  = mk("r5_g", CmdR, 5, 0, 0, 0, 0, 0, 2, 0, 0, 32'h0040_0012, 32'h41, 32'h47);
        vecs[8]  = mk("wr9", CmdWr, 3, 32'hFFFF_FFF9, 32'h01FF_E000, 32'h0123_4077,
                      32'h0123_4567, 32'h0000_0ABC, 2, 0, 0, 0, 0, 0);
        vecs[9]  = mk("r9", CmdR, 9, 0, 0, 0, 0, 0, 2, 0, 32'h01FF_E000, 32'h0123_4077,
                      32'h0123_4566, 32'h0000_0ABC);
        vecs[10] = mk("p_masked_hit9", CmdP, 0, 0, 0, 32'h001E_0077, 0, 0, 11, 32'd9,
                      0, 0, 0, 0);
        vecs[11] = mk("p_masked_asid_miss", CmdP, 0, 0, 0, 32'h001E_0078, 0, 0, 17,
                      32'h8000_0000, 0, 0, 0, 0);

        #12;
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset done", 32'(bus.done_o), 32'd0);
        chk("reset strobes", 32'({bus.wb_index_we_o, bus.wb_entry_we_o}), 32'd0);
        chk("reset index_o", bus.index_o, 32'd0);
        chk("reset entryhi_o", bus.entryhi_o, 32'd0);
        chk("reset entrylo0_o", bus.entrylo0_o, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Flush during the probe: abort with no completion and index_o left alone.
        bus.cmd_i = CmdP;
        bus.entryhi_i = 32'h0040_0012;
        bus.cmd_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.flush_i = 1'b1;
        bus.cmd_valid_i = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        chk("flush probe busy", 32'(bus.busy_o), 32'd0);
        chk("flush probe done", 32'(bus.done_o), 32'd0);
        chk("flush probe index_o", bus.index_o, 32'h8000_0000);
        count_done(20, cnt);
        chk("flush probe no done", 32'(cnt), 32'd0);

        // Non-one-hot command is never accepted.
        bus.cmd_i = 4'b0011;
        bus.cmd_valid_i = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.busy_o) busy_cnt++;
            @(posedge clk);
            #1;
            if (bus.done_o) busy_cnt++;
        end
        bus.cmd_valid_i = 1'b0;
        chk("illegal cmd activity", 32'(busy_cnt), 32'd0);

        // Flush in IDLE blocks the accept.
        bus.cmd_i = CmdP;
        bus.flush_i = 1'b1;
        bus.cmd_valid_i = 1'b1;
        count_done(3, cnt);
        bus.cmd_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        chk("idle flush no accept busy", 32'(bus.busy_o), 32'd0);
        count_done(20, cnt);
        chk("idle flush no done", 32'(cnt), 32'd0);

        // Flush during a write is ignored; the write still commits and completes.
        bus.cmd_i = CmdWi;
        bus.index_i = 32'd2;
        bus.pagemask_i = 32'd0;
        bus.entryhi_i = 32'h0000_6055;
        bus.entrylo0_i = 32'h3;
        bus.entrylo1_i = 32'h5;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        chk("flush write done", 32'(bus.done_o), 32'd1);
        bus.cmd_valid_i = 1'b0;
        @(posedge clk);
        #1;
        run_vec(mk("r2_after_flushed_write", CmdR, 2, 0, 0, 0, 0, 0, 2, 0, 0, 32'h0000_6055,
                   32'h3, 32'h5));

        // Reset asserted mid-probe: immediate idle and a cleared array.
        bus.cmd_i = CmdP;
        bus.entryhi_i = 32'h0040_0012;
        bus.cmd_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.cmd_valid_i = 1'b0;
        #1;
        chk("midreset busy", 32'(bus.busy_o), 32'd0);
        chk("midreset done", 32'(bus.done_o), 32'd0);
        chk("midreset index_o", bus.index_o, 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_vec(mk("r9_after_reset", CmdR, 9, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        run_vec(mk("r5_after_reset", CmdR, 5, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        run_vec(mk("p_hit0_after_reset", CmdP, 0, 0, 0, 0, 0, 0, 2, 32'd0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
